// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the MouseCtl receive side.
//   ps2_tx_state_t  : transmitter FSM states
//   PS2_CMD_*       : common mouse command bytes
//   us_to_cycles()  : converts a time in microseconds to system clock cycles
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        WAIT_FIRST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE  = 8'hF3;

    // 64-bit product: 100 MHz * 15 ms would overflow 32 bits.
    function automatic longint unsigned us_to_cycles(input longint unsigned freq,
                                                     input longint unsigned us);
        return (freq * us) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings one asynchronous PS/2 pad level into the clk domain.
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw        : raw pad level (asynchronous)
//   level      : synchronized level, accepted only after FILTER_LEN stable cycles
//   fall       : 1-cycle pulse when level goes 1 -> 0
module ps2_line_sync #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int unsigned   FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [FW-1:0] flt_cnt;

    // Idle bus is high, so everything resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            // stage p0 -> p1: two-flop metastability guard
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            fall    <= 1'b0;
            // stage p1 -> level: accept only a value that differs for FILTER_LEN cycles in a row
            if (sync_p1 == level) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                level   <= sync_p1;
                flt_cnt <= '0;
                fall    <= level;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte on the open-drain
// ps2_clk/ps2_data lines (request-to-send, 8 data bits LSB first, odd parity, stop) and
// checks the device ACK bit.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   tx_data      : byte to send; taken when tx_valid && tx_ready
//   tx_valid     : send request
//   tx_ready     : high only while idle
//   busy         : high from acceptance until done/err
//   done, err    : mutually exclusive 1-cycle completion pulses
//   ps2_clk_i    : raw clock pad level
//   ps2_data_i   : raw data pad level
//   ps2_clk_oe   : 1 = pull clock pad low
//   ps2_data_oe  : 1 = pull data pad low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned INHIBIT_US   = 100,
    parameter int unsigned START_TMO_US = 15_000,
    parameter int unsigned FRAME_TMO_US = 2_000,
    parameter int unsigned FILTER_LEN   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INHIBIT_CYC = 32'(us_to_cycles(64'(CLK_FREQ_HZ), 64'(INHIBIT_US)));
    localparam int unsigned START_CYC   = 32'(us_to_cycles(64'(CLK_FREQ_HZ), 64'(START_TMO_US)));
    localparam int unsigned FRAME_CYC   = 32'(us_to_cycles(64'(CLK_FREQ_HZ), 64'(FRAME_TMO_US)));
    localparam int unsigned MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam int unsigned CNT_MAX     = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
    localparam int          CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] INH_END    = CNT_W'(INHIBIT_CYC);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    ps2_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       bcnt_q, bcnt_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic [7:0]       shreg;
    logic             parity;
    logic             load_en, shift_en;
    logic             clk_lvl, clk_fall, data_lvl, data_fall_unused;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk_i),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data_i),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    // Saturating so a stuck state can never wrap back under a timeout threshold.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        bcnt_d    = bcnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    load_en  = 1'b1;
                    bcnt_d   = 4'd0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes low one cycle before the clock is released.
                if (cnt_q == INH_LAST) data_oe_d = 1'b1;
                if (cnt_q == INH_END) begin
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg[0];
                    shift_en  = 1'b1;
                    bcnt_d    = 4'd1;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else if (cnt_q == START_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ERR;
                end
            end
            SHIFT: begin
                // cnt spans the whole frame, not a single bit.
                if (cnt_q == FRAME_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ERR;
                end else if (clk_fall) begin
                    if (bcnt_q <= 4'd7) begin
                        data_oe_d = ~shreg[0];
                        shift_en  = 1'b1;
                        bcnt_d    = bcnt_q + 4'd1;
                    end else if (bcnt_q == 4'd8) begin
                        data_oe_d = ~parity;
                        bcnt_d    = 4'd9;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                data_oe_d = 1'b0;
                if (cnt_q == FRAME_LAST) begin
                    clk_oe_d = 1'b0;
                    state_d  = ERR;
                end else if (clk_fall) begin
                    state_d = data_lvl ? ERR : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (cnt_q == FRAME_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ERR;
                end else if (clk_lvl && data_lvl) begin
                    state_d = DONE;
                end
            end
            DONE, ERR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Frame byte and parity: plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (load_en) begin
            shreg  <= tx_data;
            parity <= ~^tx_data;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = ~tx_ready;
    assign done        = (state_q == DONE);
    assign err         = (state_q == ERR);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed/randomized bench with a behavioural PS/2 device on an
// open-drain bus model. Timing is scaled down: 4 MHz system clock, 12.5 kHz device clock.
module tb_ps2_host_tx;

    localparam int CLK_HZ    = 4_000_000;
    localparam int INH_US    = 100;
    localparam int START_US  = 1_000;
    localparam int FRAME_US  = 2_000;
    localparam int FLT       = 8;
    localparam int INH_EXP   = INH_US * (CLK_HZ / 1_000_000);
    localparam int START_EXP = START_US * (CLK_HZ / 1_000_000);
    localparam int HALF      = CLK_HZ / 12_500 / 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .INHIBIT_US  (INH_US),
        .START_TMO_US(START_US),
        .FRAME_TMO_US(FRAME_US),
        .FILTER_LEN  (FLT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Wired-AND open-drain bus: either side may pull low.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done)         done_cnt <= done_cnt + 1;
            if (err)          err_cnt  <= err_cnt + 1;
            if (done && err)  both_cnt <= both_cnt + 1;
        end
    end

    // Reference frame as seen by the device after falls 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Request a byte, check acceptance and the inhibit / request-to-send sequence.
    // Returns at the first sample where the host has released the clock.
    task automatic start_and_release(input logic [7:0] b, input bit hold);
        int inh;
        bit seen;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        check("accepted_busy", 32'({busy, tx_ready}), 32'(2'b10));
        if (hold) tx_data = 8'h55;
        else      tx_valid = 1'b0;
        inh  = 0;
        seen = 0;
        for (int i = 0; i < INH_EXP + 100; i++) begin
            if (ps2_data_oe) begin
                seen = 1;
                break;
            end
            if (ps2_clk_oe) inh++;
            @(negedge clk);
        end
        check("start_bit_seen", 32'(seen), 1);
        check("inhibit_len", inh, INH_EXP);
        check("start_with_clk_low", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b11));
        @(negedge clk);
        check("clk_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b01));
    endtask

    // Device model: generates up to n_max falls (11 = full frame with ACK bit).
    task automatic dev_frame(input int n_max, input bit ack_ok, input int glitch_after,
                             output logic [9:0] bits, output int err_lat);
        bits    = '0;
        err_lat = -1;
        repeat (50) @(negedge clk);
        for (int k = 1; k <= 11 && k <= n_max; k++) begin
            if (k == 11) begin
                dev_data = ack_ok ? 1'b0 : 1'b1;
                repeat (20) @(negedge clk);
            end
            dev_clk = 1'b0;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (k == 11 && err && err_lat < 0) err_lat = c;
            end
            if (k <= 10) bits[k-1] = ps2_data_i;
            dev_clk = 1'b1;
            if (k == glitch_after) begin
                repeat (60) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 63) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic full_frame(input logic [7:0] b, input bit hold, input int glitch_after,
                              output logic [9:0] bits);
        int d0, e0, lat;
        bit saw;
        d0 = done_cnt;
        e0 = err_cnt;
        start_and_release(b, hold);
        dev_frame(11, 1'b1, glitch_after, bits, lat);
        check("frame_bits", 32'(bits), 32'(frame_bits(b)));
        check("no_err_on_ack", lat, -1);
        saw = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                saw = 1;
                break;
            end
            if (err) break;
        end
        tx_valid = 1'b0;
        check("done_pulse", 32'(saw), 1);
        @(negedge clk);
        check("idle_after_done", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe}), 32'(4'b1000));
        check("one_done", done_cnt - d0, 1);
        check("no_err", err_cnt - e0, 0);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        int         k, lat, d0, e0, hits;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe}), 32'(6'b100000));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_ready", 32'({tx_ready, busy}), 32'(2'b10));

        // 1: enable reporting
        full_frame(8'hF4, 1'b0, 0, bits);
        check("f4_bits", 32'(bits), 32'(10'b10_1111_0100));

        // 2: reset command, parity bit set
        full_frame(8'hFF, 1'b0, 0, bits);
        check("ff_parity", 32'(bits[8]), 1);

        // 3: device never clocks
        e0 = err_cnt;
        start_and_release(8'(($urandom)), 1'b0);
        k = 0;
        for (int i = 0; i < START_EXP + 200; i++) begin
            @(negedge clk);
            k++;
            if (err) break;
        end
        check("start_timeout", k, START_EXP);
        check("tmo_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        @(negedge clk);
        check("tmo_ready", 32'(tx_ready), 1);
        check("tmo_err_once", err_cnt - e0, 1);

        // 4: device answers without ACK, then a normal frame
        d0 = done_cnt;
        e0 = err_cnt;
        b  = 8'($urandom);
        start_and_release(b, 1'b0);
        dev_frame(11, 1'b0, 0, bits, lat);
        check("nack_frame_bits", 32'(bits), 32'(frame_bits(b)));
        check("nack_err_latency", 32'(lat > 0 && lat <= 2 + FLT + 2), 1);
        repeat (50) @(negedge clk);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_err_once", err_cnt - e0, 1);
        full_frame(8'($urandom), 1'b0, 0, bits);

        // 5: reset mid-frame after five data bits
        b = 8'($urandom) & 8'hEF;
        start_and_release(b, 1'b0);
        dev_frame(5, 1'b1, 0, bits, lat);
        check("pre_reset_bits", 32'(bits[4:0]), 32'(b[4:0]));
        check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("reset_releases_lines", 32'({ps2_clk_oe, ps2_data_oe}), 0);
        check("reset_ready", 32'({tx_ready, busy}), 32'(2'b10));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_reset_no_done", done_cnt - d0, 0);
        check("post_reset_no_err", err_cnt - e0, 0);
        check("post_reset_ready", 32'(tx_ready), 1);

        // 6: tx_valid held with 0x55 while busy, plus a short clock glitch
        b = 8'($urandom);
        full_frame(b, 1'b1, 3, bits);
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_ready || ps2_clk_oe || ps2_data_oe) hits++;
        end
        check("no_second_frame", hits, 0);

        // random traffic
        for (int n = 0; n < 2; n++) full_frame(8'($urandom), 1'b0, 0, bits);

        repeat (5) @(negedge clk);
        check("done_err_exclusive", both_cnt, 0);
        check("total_done", done_cnt, 6);
        check("total_err", err_cnt, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
